// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider answering the EX-stage DIV/DIVU handshake.
// Returns {remainder, quotient} on result_o while ready_o is high.
// Optional macro DIV_EARLY_TERM_EN skips the leading-zero iterations of the dividend.
module div_unit #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               signed_div_i,
   input  logic [WIDTH-1:0]   opdata1_i,
   input  logic [WIDTH-1:0]   opdata2_i,
   input  logic               start_i,
   input  logic               annul_i,
   output logic [2*WIDTH-1:0] result_o,
   output logic               ready_o
);
   localparam int CW = $clog2(WIDTH + 1);
   typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;
   state_t             state_q;
   logic [CW-1:0]      cnt_q;
   logic [2*WIDTH:0]   shreg_q;
   logic [WIDTH-1:0]   divisor_q;
   logic               qneg_q;
   logic               rneg_q;
   logic [2*WIDTH-1:0] result_q;
   logic               ready_q;
   logic               neg1;
   logic               neg2;
   logic [WIDTH-1:0]   mag1;
   logic [WIDTH-1:0]   mag2;
   logic [WIDTH+1:0]   trial;
   logic [2*WIDTH:0]   shreg_d;
   logic [WIDTH-1:0]   quot;
   logic [WIDTH-1:0]   rem;
   logic [2*WIDTH:0]   init_shreg;
   logic [CW-1:0]      init_cnt;
   logic               skip;

   // Operand magnitudes; the sign bits only matter for DIV.
   assign neg1 = signed_div_i & opdata1_i[WIDTH-1];
   assign neg2 = signed_div_i & opdata2_i[WIDTH-1];
   assign mag1 = neg1 ? -opdata1_i : opdata1_i;
   assign mag2 = neg2 ? -opdata2_i : opdata2_i;

   // One restoring step: a borrow out of the trial subtract means the quotient bit is 0.
   assign trial   = {1'b0, shreg_q[2*WIDTH:WIDTH]} - {2'b0, divisor_q};
   assign shreg_d = trial[WIDTH+1] ? {shreg_q[2*WIDTH-1:0], 1'b0}
                                   : {trial[WIDTH-1:0], shreg_q[WIDTH-1:0], 1'b1};

   // Sign correction applied when the last iteration has completed.
   assign quot = qneg_q ? -shreg_q[WIDTH-1:0] : shreg_q[WIDTH-1:0];
   assign rem  = rneg_q ? -shreg_q[2*WIDTH:WIDTH+1] : shreg_q[2*WIDTH:WIDTH+1];

`ifdef DIV_EARLY_TERM_EN
   function automatic logic [CW-1:0] lzc(input logic [WIDTH-1:0] v);
      logic [CW-1:0] n;
      n = CW'(WIDTH);
      for (int i = 0; i < WIDTH; i++)
         if (v[i]) n = CW'(WIDTH - 1 - i);
      return n;
   endfunction

   // Leading zeros of the dividend would only produce zero quotient bits, so skip them.
   assign init_cnt   = lzc(mag1);
   assign init_shreg = {{WIDTH{1'b0}}, mag1, 1'b0} << init_cnt;
   assign skip       = (mag1 == '0);
`else
   assign init_cnt   = '0;
   assign init_shreg = {{WIDTH{1'b0}}, mag1, 1'b0};
   assign skip       = 1'b0;
`endif

   // Divider FSM with registered result and ready.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= FREE;
         cnt_q     <= '0;
         shreg_q   <= '0;
         divisor_q <= '0;
         qneg_q    <= 1'b0;
         rneg_q    <= 1'b0;
         result_q  <= '0;
         ready_q   <= 1'b0;
      end else begin
         case (state_q)
            FREE: if (start_i && !annul_i) begin
               divisor_q <= mag2;
               qneg_q    <= neg1 ^ neg2;
               rneg_q    <= neg1;
               cnt_q     <= init_cnt;
               shreg_q   <= init_shreg;
               state_q   <= (opdata2_i == '0 || skip) ? BYZERO : ON;
            end
            BYZERO: begin
               state_q  <= annul_i ? FREE : END;
               ready_q  <= !annul_i;
               result_q <= '0;
            end
            ON: if (annul_i) begin
               state_q <= FREE;
            end else if (cnt_q == CW'(WIDTH)) begin
               result_q <= {rem, quot};
               ready_q  <= 1'b1;
               state_q  <= END;
            end else begin
               shreg_q <= shreg_d;
               cnt_q   <= cnt_q + CW'(1);
            end
            END: if (!start_i) begin
               state_q  <= FREE;
               ready_q  <= 1'b0;
               result_q <= '0;
            end
         endcase
      end
   end

   assign result_o = result_q;
   assign ready_o  = ready_q;
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed checks of div_unit latency, results, annul and reset behaviour.
module tb_div_unit;
`ifdef DIV_EARLY_TERM_EN
   localparam bit ET = 1'b1;
`else
   localparam bit ET = 1'b0;
`endif
   localparam int AE = ET ? 3 : 10;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        signed_div = 1'b0;
   logic        start = 1'b0;
   logic        annul = 1'b0;
   logic [31:0] op1 = '0;
   logic [31:0] op2 = '0;
   logic [63:0] result;
   logic        ready;
   int          total = 0;
   int          bad = 0;

   div_unit #(.WIDTH(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .signed_div_i(signed_div),
      .opdata1_i   (op1),
      .opdata2_i   (op2),
      .start_i     (start),
      .annul_i     (annul),
      .result_o    (result),
      .ready_o     (ready)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic divide(input string tag, input logic sg, input logic [31:0] a, input logic [31:0] b,
                         input int full_lat, input int early_lat, input logic [63:0] exp);
      int n;
      n = 0;
      signed_div = sg;
      op1 = a;
      op2 = b;
      start = 1'b1;
      do begin
         tick();
         n++;
         op1 = ~a;
         op2 = b ^ 32'h5A5A_5A5A;
      end while (!ready && n < 100);
      chk({tag, "_lat"}, 64'(n), 64'(ET ? early_lat : full_lat));
      chk({tag, "_res"}, result, exp);
      annul = 1'b1;
      repeat (2) tick();
      annul = 1'b0;
      chk({tag, "_hold_rdy"}, 64'(ready), 64'd1);
      chk({tag, "_hold_res"}, result, exp);
      start = 1'b0;
      tick();
      chk({tag, "_free_rdy"}, 64'(ready), 64'd0);
      chk({tag, "_free_res"}, result, 64'd0);
   endtask

   initial begin
      int n;
      #3;
      chk("reset_rdy", 64'(ready), 64'd0);
      chk("reset_res", result, 64'd0);
      tick();
      tick();
      rst = 1'b1;
      tick();
      divide("divu_100_7", 1'b0, 32'd100, 32'd7, 34, 9, {32'd2, 32'd14});
      divide("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 34, 5, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      divide("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 34, 5, {32'd1, 32'hFFFF_FFFD});
      divide("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 34, 34, {32'd0, 32'h8000_0000});
      divide("divu_ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 34, 34, {32'h8000_0000, 32'd0});
      divide("divu_by0", 1'b0, 32'h0000_1234, 32'd0, 2, 2, 64'd0);
      divide("divu_max_16", 1'b0, 32'hFFFF_FFFF, 32'h10, 34, 34, {32'hF, 32'h0FFF_FFFF});
      divide("divu_big", 1'b0, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 34, 34, {32'hFFFF_FFFE, 32'd0});
      divide("divu_0_5", 1'b0, 32'd0, 32'd5, 34, 2, 64'd0);
      // annul while iterating
      signed_div = 1'b0;
      op1 = 32'd100;
      op2 = 32'd7;
      start = 1'b1;
      repeat (AE - 1) tick();
      annul = 1'b1;
      tick();
      annul = 1'b0;
      start = 1'b0;
      n = 0;
      repeat (40) begin
         tick();
         if (ready) n++;
      end
      chk("annul_on", 64'(n), 64'd0);
      divide("after_annul", 1'b0, 32'd100, 32'd7, 34, 9, {32'd2, 32'd14});
      // annul in BYZERO
      op1 = 32'h1234;
      op2 = 32'd0;
      start = 1'b1;
      tick();
      annul = 1'b1;
      tick();
      annul = 1'b0;
      start = 1'b0;
      n = 0;
      repeat (10) begin
         tick();
         if (ready) n++;
      end
      chk("annul_byzero", 64'(n), 64'd0);
      // annul and start together in FREE never accept
      op1 = 32'd100;
      op2 = 32'd7;
      start = 1'b1;
      annul = 1'b1;
      n = 0;
      repeat (40) begin
         tick();
         if (ready) n++;
      end
      chk("annul_free", 64'(n), 64'd0);
      annul = 1'b0;
      divide("after_block", 1'b0, 32'd100, 32'd7, 34, 9, {32'd2, 32'd14});
      // async reset mid-division
      op1 = 32'd100;
      op2 = 32'd7;
      start = 1'b1;
      repeat (19) tick();
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("rst_mid_rdy", 64'(ready), 64'd0);
      chk("rst_mid_res", result, 64'd0);
      start = 1'b0;
      #2 rst = 1'b1;
      n = 0;
      repeat (40) begin
         tick();
         if (ready) n++;
      end
      chk("rst_mid_idle", 64'(n), 64'd0);
      // async reset while holding a result
      op1 = 32'd100;
      op2 = 32'd7;
      start = 1'b1;
      n = 0;
      do begin
         tick();
         n++;
      end while (!ready && n < 100);
      chk("rst_end_pre", result, {32'd2, 32'd14});
      #2 rst = 1'b0;
      #1;
      chk("rst_end_rdy", 64'(ready), 64'd0);
      chk("rst_end_res", result, 64'd0);
      start = 1'b0;
      #2 rst = 1'b1;
      tick();
      divide("after_rst", 1'b1, 32'hFFFF_FFF9, 32'd2, 34, 5, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
